// File: rtl/logic_unit_pkg.sv
// Opcode type and the bitwise function table shared by the logic unit pipeline.
// The LOGIC_UNIT_POPCOUNT_EN option does not change anything in this package.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_AND    = 3'b001,
    OP_OR     = 3'b010,
    OP_XOR    = 3'b011,
    OP_NOT_A  = 3'b100,
    OP_NAND   = 3'b101,
    OP_NOR    = 3'b110,
    OP_XNOR   = 3'b111
  } op_t;

  // Widest operand logic_fn handles; callers zero-extend into it and truncate the result.
  localparam int FN_MAX_W = 256;

  typedef logic [FN_MAX_W-1:0] fn_word_t;

  function automatic fn_word_t logic_fn(input fn_word_t a, input fn_word_t b, input op_t op);
    case (op)
      OP_PASS_A: return a;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_NOT_A:  return ~a;
      OP_NAND:   return ~(a & b);
      OP_NOR:    return ~(a | b);
      default:   return ~(a ^ b);
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle between operand fetch, the logic unit and writeback.
// Carries the popcount result only when LOGIC_UNIT_POPCOUNT_EN is defined.
interface logic_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] op_count;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] popcount;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, zero, parity, op_count, popcount);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, zero, parity, op_count, popcount);
`else
  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, zero, parity, op_count);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, zero, parity, op_count);
`endif
endinterface

// File: rtl/logic_unit_stage.sv
// Generic valid/ready pipeline register: holds one payload, accepts a new one
// whenever it is empty or its current payload is being taken downstream.
module logic_unit_stage #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // NOTE: state registers use <= so every flop samples pre-edge values; '=' here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      // NOTE: the payload is a single register, not a memory, so it is reset; downstream flags depend on its reset value.
      out_data  <= RST_VAL;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined 8-function bitwise logic unit with zero/parity flags and a consumed-result counter.
// Define LOGIC_UNIT_POPCOUNT_EN to add a registered popcount of the result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  logic_unit_if.slave bus
);

  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int S1_W = 2 * WIDTH + 3;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int S2_W = WIDTH + 2 + PC_W;
`else
  localparam int S2_W = WIDTH + 2;
`endif
  // S2 payload is {[popcount,] parity, zero, result}; after reset only the zero flag is set.
  localparam logic [S2_W-1:0] S2_RST = S2_W'(1) << WIDTH;

  if (WIDTH < 2 || WIDTH > FN_MAX_W) begin : g_width_check
    $error("logic_unit_pipe: WIDTH must be in 2..FN_MAX_W");
  end

  logic             s1_valid;
  logic             s1_in_ready;
  logic             s2_in_ready;
  logic             s2_valid;
  logic [S1_W-1:0]  s1_data;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] fn_res;
  logic [S2_W-1:0]  s2_next;
  logic [S2_W-1:0]  s2_data;
  logic [CNT_W-1:0] op_count_q;

  logic_unit_stage #(.W(S1_W), .RST_VAL('0)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (s1_in_ready),
    .in_data   ({bus.op, bus.b, bus.a}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign {s1_op, s1_b, s1_a} = s1_data;
  assign fn_res = WIDTH'(logic_fn(fn_word_t'(s1_a), fn_word_t'(s1_b), op_t'(s1_op)));

  always_comb begin
    // NOTE: default every bit first so no path leaves s2_next unassigned, which would infer a latch.
    s2_next            = '0;
    s2_next[WIDTH-1:0] = fn_res;
    s2_next[WIDTH]     = ~|fn_res;
    s2_next[WIDTH+1]   = ^fn_res;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    for (int i = 0; i < WIDTH; i++) begin
      s2_next[S2_W-1 -: PC_W] = s2_next[S2_W-1 -: PC_W] + PC_W'(fn_res[i]);
    end
`endif
  end

  logic_unit_stage #(.W(S2_W), .RST_VAL(S2_RST)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_next),
    .out_valid (s2_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_data)
  );

  // Held low during reset so the producer never sees a handshake the flops will discard.
  assign bus.in_ready  = rst_n && s1_in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_data[WIDTH-1:0];
  assign bus.zero      = s2_data[WIDTH];
  assign bus.parity    = s2_data[WIDTH+1];
`ifdef LOGIC_UNIT_POPCOUNT_EN
  assign bus.popcount  = s2_data[S2_W-1 -: PC_W];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (s2_valid && bus.out_ready) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver queues hand-computed results on
// acceptance, an independent monitor pops and compares on every output consume.
module tb_logic_unit_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  localparam logic [31:0] LA = 32'hDC754CD2;
  localparam logic [31:0] LB = 32'h4124F055;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        zero;
    logic        parity;
    bit          lat_chk;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Hand-computed results for LA/LB indexed by opcode.
  logic [31:0] exp_tab [8] = '{32'hDC754CD2, 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87,
                               32'h238AB32D, 32'hBFDBBFAF, 32'h228A0328, 32'h62AE4378};

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  logic [CNT_W-1:0] exp_count = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, after inputs settle and well before the next edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output_valid", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result, e.result);
        check({e.name, "_zero"},   bus.zero,   e.zero);
        check({e.name, "_parity"}, bus.parity, e.parity);
        if (e.lat_chk) check({e.name, "_latency"}, cyc, e.acc_cyc + 1);
        exp_count = exp_count + 1'b1;
      end
    end
  end

  task automatic issue_x(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] res, input bit lat,
                         output int stalls, output bit cons);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    #1;
    stalls = 0;
    cons   = 1'b0;
    while (!bus.in_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!bus.in_ready) begin
      check({name, "_accept_timeout"}, bus.in_ready, 1'b1);
    end else begin
      cons      = bus.out_valid && bus.out_ready;
      e.name    = name;
      e.result  = res;
      e.zero    = (res == 32'h0);
      e.parity  = ^res;
      e.lat_chk = lat;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] res, input bit lat);
    int s;
    bit c;
    issue_x(name, a, b, op, res, lat, s, c);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 'x;
    bus.b        = 'x;
    bus.op       = 'x;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (sb.size() != 0) check({name, "_drain_timeout"}, sb.size(), 0);
    @(negedge clk);
    #3;
    check({name, "_op_count"}, bus.op_count, exp_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit cons;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = 'x;
    bus.b         = 'x;
    bus.op        = 'x;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready_low", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result",    bus.result,    32'h0);
    check("rst_zero",      bus.zero,      1'b1);
    check("rst_parity",    bus.parity,    1'b0);
    check("rst_op_count",  bus.op_count,  4'd0);
    check("rst_in_ready",  bus.in_ready,  1'b1);

    // Legacy AND/OR/XOR back-to-back: each result must appear two cycles after its accept.
    issue("leg_and", LA, LB, 3'b001, 32'h40244050, 1'b1);
    issue("leg_or",  LA, LB, 3'b010, 32'hDD75FCD7, 1'b1);
    issue("leg_xor", LA, LB, 3'b011, 32'h9D51BC87, 1'b1);
    idle();
    drain("legacy");
    check("legacy_op_count_3", bus.op_count, 4'd3);

    issue("inv_nand",  LA, LB, 3'b101, 32'hBFDBBFAF, 1'b1);
    issue("inv_nor",   LA, LB, 3'b110, 32'h228A0328, 1'b1);
    issue("inv_xnor",  LA, LB, 3'b111, 32'h62AE4378, 1'b1);
    issue("inv_not_a", LA, LB, 3'b100, 32'h238AB32D, 1'b1);
    issue("pass_a",    LA, LB, 3'b000, 32'hDC754CD2, 1'b1);
    idle();
    drain("inverted");

    issue("flag_xor_zero", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000000, 1'b0);
    issue("flag_or_one",   32'h00000001, 32'h00000000, 3'b010, 32'h00000001, 1'b0);
    idle();
    drain("flags");

    // Backpressure: two accepts fill the pipe, the third waits until the first is consumed.
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue("bp_and", LA, LB, 3'b001, 32'h40244050, 1'b0);
    issue("bp_or",  LA, LB, 3'b010, 32'hDD75FCD7, 1'b0);
    fork
      issue_x("bp_xor", LA, LB, 3'b011, 32'h9D51BC87, 1'b0, stalls, cons);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          check("bp_held_valid",  bus.out_valid, 1'b1);
          check("bp_held_result", bus.result,    32'h40244050);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    check("bp_stall_cycles",        stalls, 3);
    check("bp_accept_with_consume", cons,   1'b1);
    idle();
    drain("backpressure");

    // Reset with both stages holding results: nothing may come out afterwards.
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue("rst_a", LA, LB, 3'b001, 32'h40244050, 1'b0);
    issue("rst_b", LA, LB, 3'b010, 32'hDD75FCD7, 1'b0);
    idle();
    #1;
    check("full_out_valid", bus.out_valid, 1'b1);
    check("full_in_ready",  bus.in_ready,  1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_in_ready_low", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = '0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_op_count",  bus.op_count,  4'd0);
    check("midrst_zero",      bus.zero,      1'b1);
    check("midrst_result",    bus.result,    32'h0);
    check("midrst_in_ready",  bus.in_ready,  1'b1);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_stale", bus.out_valid, 1'b0);

    // 17 consumes on a 4-bit counter wrap it to 1.
    for (int i = 0; i < 17; i++) begin
      issue("wrap", LA, LB, 3'(i % 8), exp_tab[i % 8], 1'b1);
    end
    idle();
    drain("wrap");
    check("wrap_op_count_1", bus.op_count, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
